// File: rtl/collision_monitor_if.sv
// Signal bundle between the game logic and the collision monitor.
// The strobes are single-cycle qualifiers with no backpressure: edge_detected
// and frame_end count in the cycle they are high, start is a level sampled
// every cycle, and every monitor output is a registered value.
interface collision_monitor_if;
   logic        edge_detected;
   logic        frame_end;
   logic        start;
   logic        crash;
   logic        respawn;
   logic        freeze;
   logic        game_over;
   logic [1:0]  lives_left;
   logic [15:0] score;
   logic [1:0]  state;

   modport master (
      output edge_detected, frame_end, start,
      input  crash, respawn, freeze, game_over, lives_left, score, state
   );

   modport slave (
      input  edge_detected, frame_end, start,
      output crash, respawn, freeze, game_over, lives_left, score, state
   );
endinterface

// File: rtl/collision_monitor.sv
// Collision monitor for a bike game: turns per-pixel edge hits into
// per-frame hits, registers a crash after GRACE_FRAMES consecutive hit
// frames, tracks lives and score, and freezes the bike during respawn.
module collision_monitor #(
   parameter int LIVES          = 3,
   parameter int GRACE_FRAMES   = 2,
   parameter int RESPAWN_FRAMES = 60
) (
   input logic                 clock,
   input logic                 reset,
   collision_monitor_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAY    = 2'd1,
      CRASHED = 2'd2,
      OVER    = 2'd3
   } state_t;

   localparam logic [1:0] LIVES_INIT = 2'(LIVES);
   localparam logic [2:0] GRACE_N    = 3'(GRACE_FRAMES);
   localparam logic [7:0] RESP_N     = 8'(RESPAWN_FRAMES);

   state_t      state_q;
   logic        crash_q;
   logic        respawn_q;
   logic        freeze_q;
   logic        game_over_q;
   logic [1:0]  lives_q;
   logic [15:0] score_q;
   logic        hit_flag;
   logic [2:0]  consec;
   logic [7:0]  resp_cnt;
   logic        frame_hit;

   // A frame counts as hit if any pixel hit earlier in the frame or on its last cycle.
   assign frame_hit = hit_flag | bus.edge_detected;

   // Game FSM; every output comes straight from a register in this block.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         crash_q     <= 1'b0;
         respawn_q   <= 1'b0;
         freeze_q    <= 1'b1;
         game_over_q <= 1'b0;
         lives_q     <= LIVES_INIT;
         score_q     <= 16'd0;
         hit_flag    <= 1'b0;
         consec      <= 3'd0;
         resp_cnt    <= 8'd0;
      end else begin
         crash_q   <= 1'b0;
         respawn_q <= 1'b0;
         case (state_q)
            IDLE: begin
               freeze_q <= 1'b1;
               if (bus.start) begin
                  state_q  <= PLAY;
                  lives_q  <= LIVES_INIT;
                  score_q  <= 16'd0;
                  hit_flag <= 1'b0;
                  consec   <= 3'd0;
                  freeze_q <= 1'b0;
               end
            end
            PLAY: begin
               if (bus.frame_end) begin
                  hit_flag <= 1'b0;
                  if (frame_hit && (consec + 3'd1 == GRACE_N)) begin
                     // Crash frame: no score, lose a life, freeze the bike.
                     consec   <= 3'd0;
                     crash_q  <= 1'b1;
                     freeze_q <= 1'b1;
                     if (lives_q <= 2'd1) begin
                        lives_q     <= 2'd0;
                        state_q     <= OVER;
                        game_over_q <= 1'b1;
                     end else begin
                        lives_q  <= lives_q - 2'd1;
                        state_q  <= CRASHED;
                        resp_cnt <= RESP_N;
                     end
                  end else begin
                     consec <= frame_hit ? consec + 3'd1 : 3'd0;
                     if (score_q != 16'hFFFF) begin
                        score_q <= score_q + 16'd1;
                     end
                  end
               end else if (bus.edge_detected) begin
                  hit_flag <= 1'b1;
               end
            end
            CRASHED: begin
               // Edge hits are ignored while frozen; only frame_end matters.
               if (bus.frame_end) begin
                  if (resp_cnt == 8'd1) begin
                     state_q   <= PLAY;
                     resp_cnt  <= 8'd0;
                     freeze_q  <= 1'b0;
                     respawn_q <= 1'b1;
                     hit_flag  <= 1'b0;
                     consec    <= 3'd0;
                  end else begin
                     resp_cnt <= resp_cnt - 8'd1;
                  end
               end
            end
            OVER: begin
               if (bus.start) begin
                  state_q     <= PLAY;
                  lives_q     <= LIVES_INIT;
                  score_q     <= 16'd0;
                  game_over_q <= 1'b0;
                  freeze_q    <= 1'b0;
                  hit_flag    <= 1'b0;
                  consec      <= 3'd0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.state      = state_q;
   assign bus.crash      = crash_q;
   assign bus.respawn    = respawn_q;
   assign bus.freeze     = freeze_q;
   assign bus.game_over  = game_over_q;
   assign bus.lives_left = lives_q;
   assign bus.score      = score_q;

endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor with default parameters
// (LIVES=3, GRACE_FRAMES=2, RESPAWN_FRAMES=60).
module tb_collision_monitor;

   logic clock;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   collision_monitor_if bus ();

   collision_monitor dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Clock and initial input levels.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic e, input logic f, input logic s);
      bus.edge_detected = e;
      bus.frame_end     = f;
      bus.start         = s;
   endtask

   // One frame ending with an edge hit on its last cycle.
   task automatic hit_frame();
      drive(1'b1, 1'b1, 1'b0); tick(); drive(1'b0, 1'b0, 1'b0);
   endtask

   // Two consecutive hit frames from consec=0 produce a crash.
   task automatic crash_seq();
      drive(1'b1, 1'b1, 1'b1); tick();  // start ignored in PLAY
      hit_frame();
   endtask

   task automatic respawn_seq();
      for (int i = 0; i < 60; i++) begin
         drive(1'b0, 1'b1, 1'b0); tick();
      end
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1; drive(1'b1, 1'b1, 1'b1); tick();
      reset = 1'b0; drive(1'b0, 1'b0, 1'b0);
      checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
      checks++; if (bus.lives_left !== 2'd3) begin errors++; $display("FAIL reset_lives: got %0d want 3", bus.lives_left); end
      checks++; if (bus.score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", bus.score); end
      checks++; if ({bus.freeze, bus.crash, bus.respawn, bus.game_over} !== 4'b1000) begin errors++; $display("FAIL reset_flags: got %b want 1000", {bus.freeze, bus.crash, bus.respawn, bus.game_over}); end
      tick();
      checks++; if (bus.state !== 2'd0 || bus.freeze !== 1'b1) begin errors++; $display("FAIL idle_hold: got state %0d freeze %b want 0 1", bus.state, bus.freeze); end
   endtask

   task automatic test_start();
      drive(1'b0, 1'b0, 1'b1); tick(); drive(1'b0, 1'b0, 1'b0);
      checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", bus.state); end
      checks++; if (bus.lives_left !== 2'd3) begin errors++; $display("FAIL start_lives: got %0d want 3", bus.lives_left); end
      checks++; if (bus.freeze !== 1'b0 || bus.score !== 16'd0) begin errors++; $display("FAIL start_freeze_score: got %b %0d want 0 0", bus.freeze, bus.score); end
   endtask

   task automatic test_grace();
      // Frame A: mid-frame pulse, clean frame_end cycle.
      drive(1'b1, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0); tick(); drive(1'b0, 1'b0, 1'b0);
      checks++; if (dut.consec !== 3'd1 || bus.score !== 16'd1 || bus.crash !== 1'b0) begin errors++; $display("FAIL grace_frame_a: got consec %0d score %0d crash %b want 1 1 0", dut.consec, bus.score, bus.crash); end
      // Frame B: no hit.
      drive(1'b0, 1'b1, 1'b0); tick(); drive(1'b0, 1'b0, 1'b0);
      checks++; if (dut.consec !== 3'd0 || bus.score !== 16'd2 || bus.crash !== 1'b0 || bus.state !== 2'd1) begin errors++; $display("FAIL grace_frame_b: got consec %0d score %0d crash %b state %0d want 0 2 0 1", dut.consec, bus.score, bus.crash, bus.state); end
   endtask

   task automatic test_crash();
      // Frame C: mid-frame pulse; frame D: pulse coincident with frame_end.
      drive(1'b1, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0); tick(); drive(1'b0, 1'b0, 1'b0);
      checks++; if (dut.consec !== 3'd1 || bus.score !== 16'd3 || bus.crash !== 1'b0) begin errors++; $display("FAIL crash_frame_c: got consec %0d score %0d crash %b want 1 3 0", dut.consec, bus.score, bus.crash); end
      hit_frame();
      checks++; if (bus.crash !== 1'b1 || bus.respawn !== 1'b0) begin errors++; $display("FAIL crash_pulse: got crash %b respawn %b want 1 0", bus.crash, bus.respawn); end
      checks++; if (bus.lives_left !== 2'd2 || bus.state !== 2'd2 || bus.freeze !== 1'b1) begin errors++; $display("FAIL crash_state: got lives %0d state %0d freeze %b want 2 2 1", bus.lives_left, bus.state, bus.freeze); end
      checks++; if (bus.score !== 16'd3) begin errors++; $display("FAIL crash_score: got %0d want 3", bus.score); end
      tick();
      checks++; if (bus.crash !== 1'b0 || bus.state !== 2'd2) begin errors++; $display("FAIL crash_one_cycle: got crash %b state %0d want 0 2", bus.crash, bus.state); end
   endtask

   task automatic test_respawn();
      int bad = 0;
      drive(1'b1, 1'b0, 1'b1); tick(); drive(1'b0, 1'b0, 1'b0);
      checks++; if (dut.hit_flag !== 1'b0 || bus.state !== 2'd2) begin errors++; $display("FAIL crashed_ignores_inputs: got hit_flag %b state %0d want 0 2", dut.hit_flag, bus.state); end
      for (int i = 0; i < 59; i++) begin
         drive(1'b0, 1'b1, 1'b0); tick();
         if (bus.state !== 2'd2 || bus.respawn !== 1'b0 || bus.freeze !== 1'b1) bad++;
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (bad != 0) begin errors++; $display("FAIL respawn_wait: got %0d bad frames want 0", bad); end
      checks++; if (dut.resp_cnt !== 8'd1) begin errors++; $display("FAIL respawn_cnt59: got %0d want 1", dut.resp_cnt); end
      drive(1'b0, 1'b1, 1'b0); tick(); drive(1'b0, 1'b0, 1'b0);
      checks++; if (bus.respawn !== 1'b1 || bus.crash !== 1'b0 || bus.state !== 2'd1 || bus.freeze !== 1'b0) begin errors++; $display("FAIL respawn_fire: got respawn %b crash %b state %0d freeze %b want 1 0 1 0", bus.respawn, bus.crash, bus.state, bus.freeze); end
      checks++; if (dut.resp_cnt !== 8'd0 || dut.consec !== 3'd0) begin errors++; $display("FAIL respawn_clear: got cnt %0d consec %0d want 0 0", dut.resp_cnt, dut.consec); end
      tick();
      checks++; if (bus.respawn !== 1'b0) begin errors++; $display("FAIL respawn_one_cycle: got %b want 0", bus.respawn); end
   endtask

   task automatic test_game_over();
      crash_seq();
      checks++; if (bus.crash !== 1'b1 || bus.lives_left !== 2'd1 || bus.state !== 2'd2 || bus.score !== 16'd4) begin errors++; $display("FAIL second_crash: got crash %b lives %0d state %0d score %0d want 1 1 2 4", bus.crash, bus.lives_left, bus.state, bus.score); end
      respawn_seq();
      crash_seq();
      checks++; if (bus.lives_left !== 2'd0 || bus.state !== 2'd3 || bus.game_over !== 1'b1 || bus.freeze !== 1'b1) begin errors++; $display("FAIL third_crash: got lives %0d state %0d over %b freeze %b want 0 3 1 1", bus.lives_left, bus.state, bus.game_over, bus.freeze); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 1'b0); tick();
      end
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (bus.state !== 2'd3 || bus.lives_left !== 2'd0 || bus.score !== 16'd5 || bus.crash !== 1'b0) begin errors++; $display("FAIL over_hold: got state %0d lives %0d score %0d crash %b want 3 0 5 0", bus.state, bus.lives_left, bus.score, bus.crash); end
      drive(1'b0, 1'b0, 1'b1); tick(); drive(1'b0, 1'b0, 1'b0);
      checks++; if (bus.state !== 2'd1 || bus.lives_left !== 2'd3 || bus.score !== 16'd0 || bus.game_over !== 1'b0 || bus.freeze !== 1'b0) begin errors++; $display("FAIL over_restart: got state %0d lives %0d score %0d over %b freeze %b want 1 3 0 0 0", bus.state, bus.lives_left, bus.score, bus.game_over, bus.freeze); end
   endtask

   task automatic test_reset_mid_respawn();
      crash_seq();
      for (int i = 0; i < 30; i++) begin
         drive(1'b0, 1'b1, 1'b0); tick();
      end
      checks++; if (dut.resp_cnt !== 8'd30 || bus.state !== 2'd2) begin errors++; $display("FAIL mid_respawn_cnt: got cnt %0d state %0d want 30 2", dut.resp_cnt, bus.state); end
      reset = 1'b1; drive(1'b1, 1'b1, 1'b1); tick();
      reset = 1'b0; drive(1'b0, 1'b0, 1'b0);
      checks++; if (bus.state !== 2'd0 || bus.freeze !== 1'b1 || bus.lives_left !== 2'd3 || bus.score !== 16'd0) begin errors++; $display("FAIL mid_reset_state: got state %0d freeze %b lives %0d score %0d want 0 1 3 0", bus.state, bus.freeze, bus.lives_left, bus.score); end
      checks++; if ({bus.crash, bus.respawn, bus.game_over, dut.hit_flag} !== 4'b0000 || dut.resp_cnt !== 8'd0 || dut.consec !== 3'd0) begin errors++; $display("FAIL mid_reset_internal: got flags %b cnt %0d consec %0d want 0000 0 0", {bus.crash, bus.respawn, bus.game_over, dut.hit_flag}, dut.resp_cnt, dut.consec); end
   endtask

   task automatic test_score_saturation();
      drive(1'b0, 1'b0, 1'b1); tick();
      drive(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 65534; i++) tick();
      checks++; if (bus.score !== 16'hFFFE) begin errors++; $display("FAIL score_fffe: got %h want fffe", bus.score); end
      tick();
      checks++; if (bus.score !== 16'hFFFF) begin errors++; $display("FAIL score_ffff: got %h want ffff", bus.score); end
      tick();
      drive(1'b0, 1'b0, 1'b0);
      checks++; if (bus.score !== 16'hFFFF || bus.state !== 2'd1) begin errors++; $display("FAIL score_saturate: got %h state %0d want ffff 1", bus.score, bus.state); end
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      test_reset();
      test_start();
      test_grace();
      test_crash();
      test_respawn();
      test_game_over();
      test_reset_mid_respawn();
      test_score_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
